// File: rtl/ebpf_alu_issue_if.sv
// ebpf_alu_issue_if: instruction, issue-packet and writeback channels of the eBPF ALU issue stage
interface ebpf_alu_issue_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic [63:0]     in_instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_src;
  logic [XLEN-1:0] out_dval;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_ALUControl;
  logic            out_is64;
  logic [3:0]      out_dst;
  logic            wb_valid;
  logic [3:0]      wb_idx;
  logic [XLEN-1:0] wb_data;
  logic            err;
  modport master (
    output in_valid, in_instr, out_ready, wb_valid, wb_idx, wb_data,
    input  in_ready, out_valid, out_src, out_dval, out_imm, out_ALUControl, out_is64, out_dst, err
  );
  modport slave (
    input  in_valid, in_instr, out_ready, wb_valid, wb_idx, wb_data,
    output in_ready, out_valid, out_src, out_dval, out_imm, out_ALUControl, out_is64, out_dst, err
  );
endinterface

// File: rtl/ebpf_alu_issue.sv
// ebpf_alu_issue: decodes eBPF ALU/ALU64 instructions, reads operands and issues through a one-entry
// registered port, with a busy-bit scoreboard cleared by writeback.
module ebpf_alu_issue #(
  parameter int NREGS = 11,
  parameter int XLEN  = 64
) (
  input logic             clk,
  input logic             rst_n,
  ebpf_alu_issue_if.slave bus
);
  localparam logic [3:0] RO = 4'(NREGS - 1);
  logic [XLEN-1:0] regs_q [NREGS-1];
  logic [XLEN-1:0] regs_d [NREGS-1];
  logic [NREGS-2:0] busy_q, busy_d;
  logic out_valid_q, out_valid_d, err_q, err_d, is64_q, is64_d;
  logic [XLEN-1:0] src_q, src_d, dval_q, dval_d, imm_q, imm_d;
  logic [3:0] ctl_q, ctl_d, dst_q, dst_d;
  logic [3:0] op, dst, src;
  logic [2:0] cls;
  logic [31:0] imm;
  logic srcbit, is64, is_end, use_src, legal, hazard, acc, ld, unused_off;
  logic [XLEN-1:0] dv, sv, simm, mask;
  assign {imm, src, dst, op, srcbit, cls} =
    {bus.in_instr[63:32], bus.in_instr[15:12], bus.in_instr[11:8], bus.in_instr[7:0]};
  assign unused_off = ^bus.in_instr[31:16];
  assign is64 = cls == 3'h7;
  assign is_end = op == 4'hD;
  assign use_src = srcbit && !is_end;
  assign legal = (cls == 3'h4 || is64) && op < 4'hE && dst < RO && (!use_src || src <= RO) &&
                 (!is_end || imm == 32'd16 || imm == 32'd32 || (imm == 32'd64 && is64));
  // r10 has no busy bit since it can never be a legal destination
  assign hazard = (dst < RO && busy_q[dst]) || (use_src && src < RO && busy_q[src]);
  assign bus.in_ready = rst_n && !hazard && (!out_valid_q || bus.out_ready);
  assign acc = bus.in_valid && bus.in_ready;
  assign ld = acc && legal;
  assign dv = dst < RO ? regs_q[dst] : '0;
  assign sv = src < RO ? regs_q[src] : '0;
  assign simm = {{(XLEN-32){imm[31]}}, imm};
  assign mask = {{(XLEN-32){is64}}, 32'hFFFF_FFFF};
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (bus.wb_valid && bus.wb_idx < RO) begin
      regs_d[bus.wb_idx] = bus.wb_data;
      busy_d[bus.wb_idx] = 1'b0;
    end
    if (ld) busy_d[dst] = 1'b1;
    out_valid_d = ld || (out_valid_q && !bus.out_ready);
    err_d = err_q || (acc && !legal);
    src_d = ld ? (is_end ? dv : srcbit ? sv : simm) & mask : src_q;
    dval_d = ld ? dv & mask : dval_q;
    imm_d = ld ? (is_end ? XLEN'(imm) : simm) : imm_q;
    ctl_d = ld ? (is_end ? (srcbit ? 4'hE : 4'hD) : op) : ctl_q;
    is64_d = ld ? is64 : is64_q;
    dst_d = ld ? dst : dst_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      out_valid_q <= 1'b0;
      err_q <= 1'b0;
      src_q <= '0;
      dval_q <= '0;
      imm_q <= '0;
      ctl_q <= '0;
      is64_q <= 1'b0;
      dst_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      err_q <= err_d;
      src_q <= src_d;
      dval_q <= dval_d;
      imm_q <= imm_d;
      ctl_q <= ctl_d;
      is64_q <= is64_d;
      dst_q <= dst_d;
    end
  assign bus.out_valid = out_valid_q;
  assign bus.err = err_q;
  assign bus.out_src = src_q;
  assign bus.out_dval = dval_q;
  assign bus.out_imm = imm_q;
  assign bus.out_ALUControl = ctl_q;
  assign bus.out_is64 = is64_q;
  assign bus.out_dst = dst_q;
endmodule

// File: tb/tb_ebpf_alu_issue.sv
// tb_ebpf_alu_issue: randomized scoreboard bench; expected packets come from an architectural model
// of the register file and busy set, a separate monitor compares them as the DUT presents them.
module tb_ebpf_alu_issue;
  typedef struct packed {
    logic [63:0] src, dval, imm;
    logic [3:0]  ctl;
    logic        is64;
    logic [3:0]  dst;
  } pkt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ebpf_alu_issue_if bif();
  ebpf_alu_issue dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int checks = 0;
  int errors = 0;
  pkt_t sb[$];
  logic [3:0] wbq[$];
  logic [63:0] mregs [16];
  bit mbusy [16];
  bit merr = 0;
  bit init_done = 0;
  bit wb_keep = 1;
  int rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit legal(input logic [63:0] x);
    int op = int'(x[7:4]);
    int cls = int'(x[2:0]);
    int d = int'(x[11:8]);
    int s = int'(x[15:12]);
    longint imm = longint'(x[63:32]);
    if (cls != 4 && cls != 7) return 0;
    if (op >= 14) return 0;
    if (d >= 10) return 0;
    if (x[3] && op != 13 && s > 10) return 0;
    if (op == 13 && !(imm == 16 || imm == 32 || (imm == 64 && cls == 7))) return 0;
    return 1;
  endfunction

  function automatic bit haz(input logic [63:0] x);
    return mbusy[x[11:8]] || (x[3] && x[7:4] != 4'hD && mbusy[x[15:12]]);
  endfunction

  function automatic bit any_busy();
    foreach (mbusy[i]) if (mbusy[i]) return 1;
    return 0;
  endfunction

  function automatic pkt_t expect_pkt(input logic [63:0] x);
    pkt_t p;
    logic [63:0] simm = {{32{x[63]}}, x[63:32]};
    p.dst = x[11:8];
    p.is64 = x[2:0] == 3'd7;
    p.dval = mregs[x[11:8]];
    if (x[7:4] == 4'hD) begin
      p.src = mregs[x[11:8]];
      p.imm = {32'd0, x[63:32]};
      p.ctl = x[3] ? 4'hE : 4'hD;
    end else begin
      p.src = x[3] ? mregs[x[15:12]] : simm;
      p.imm = simm;
      p.ctl = x[7:4];
    end
    if (!p.is64) begin
      p.src = p.src & 64'hFFFF_FFFF;
      p.dval = p.dval & 64'hFFFF_FFFF;
    end
    return p;
  endfunction

  function automatic logic [63:0] rand_ins();
    logic [31:0] imms [4] = '{32'd16, 32'd32, 32'd64, 32'd8};
    logic [3:0] op = $urandom_range(7) == 0 ? 4'($urandom) : 4'($urandom_range(13));
    logic sbit = 1'($urandom_range(1));
    logic [2:0] cls = $urandom_range(9) == 0 ? 3'($urandom) : ($urandom_range(1) != 0 ? 3'h7 : 3'h4);
    logic [3:0] d = $urandom_range(19) == 0 ? 4'($urandom) : 4'($urandom_range(9));
    logic [3:0] s = $urandom_range(19) == 0 ? 4'($urandom) : 4'($urandom_range(10));
    logic [31:0] imm = $urandom;
    if ($urandom_range(3) == 0) op = 4'hD;
    if (op == 4'hD) imm = imms[$urandom_range(3)];
    return {imm, 16'($urandom), s, d, op, sbit, cls};
  endfunction

  // Present one instruction until accepted, checking in_ready against the model every cycle.
  task automatic issue(input logic [63:0] ins);
    int n = 0;
    bit er;
    bif.in_valid = 1'b1;
    bif.in_instr = ins;
    forever begin
      @(negedge clk);
      er = !haz(ins) && (bif.out_ready || sb.size() == 0);
      check("in_ready", 64'(bif.in_ready), 64'(er));
      if (bif.in_ready) break;
      if (++n > 300) begin
        check("stall_timeout", 64'(bif.in_ready), 64'(1));
        bif.in_valid = 1'b0;
        return;
      end
    end
    if (legal(ins)) begin
      sb.push_back(expect_pkt(ins));
      mbusy[ins[11:8]] = 1'b1;
    end else merr = 1'b1;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    check("err", 64'(bif.err), 64'(merr));
    if (legal(ins)) check("issue_latency", 64'(bif.out_valid), 64'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || wbq.size() != 0 || any_busy()) && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_pending", 64'(sb.size() + wbq.size()), 64'(0));
    check("drain_out_valid", 64'(bif.out_valid), 64'(0));
  endtask

  always @(negedge clk) if (rst_n && bif.out_valid) begin
    if (sb.size() == 0) check("unexpected_valid", 64'(bif.out_valid), 64'(0));
    else begin
      check("out_src", bif.out_src, sb[0].src);
      check("out_dval", bif.out_dval, sb[0].dval);
      check("out_imm", bif.out_imm, sb[0].imm);
      check("out_ctl_is64_dst", 64'({bif.out_ALUControl, bif.out_is64, bif.out_dst}),
            64'({sb[0].ctl, sb[0].is64, sb[0].dst}));
      if (bif.out_ready) begin
        wbq.push_back(sb[0].dst);
        sb.delete(0);
      end
    end
  end

  initial begin
    bif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bif.out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  initial begin : wbp
    logic [3:0] i;
    logic [63:0] d;
    bif.wb_valid = 1'b0;
    bif.wb_idx = '0;
    bif.wb_data = '0;
    wait (rst_n);
    @(posedge clk);
    #1;
    for (int k = 0; k < 11; k++) begin
      d = k == 1 ? 64'h0123_4567_89AB_CDEF : {$urandom, $urandom};
      bif.wb_valid = 1'b1;
      bif.wb_idx = 4'(k);
      bif.wb_data = d;
      @(posedge clk);
      #1;
      if (k < 10) mregs[k] = d;
    end
    bif.wb_valid = 1'b0;
    init_done = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (wbq.size() != 0 && $urandom_range(2) != 0) begin
        i = wbq.pop_front();
        d = wb_keep ? mregs[i] : {$urandom, $urandom};
        bif.wb_valid = 1'b1;
        bif.wb_idx = i;
        bif.wb_data = d;
        @(posedge clk);
        #1;
        bif.wb_valid = 1'b0;
        mregs[i] = d;
        mbusy[i] = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mregs[i]) mregs[i] = '0;
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_instr = '0;
    #12;
    check("rst_out_valid", 64'(bif.out_valid), 64'(0));
    check("rst_err", 64'(bif.err), 64'(0));
    check("rst_in_ready", 64'(bif.in_ready), 64'(0));
    check("rst_out_src", bif.out_src, 64'(0));
    check("rst_out_misc", 64'({bif.out_ALUControl, bif.out_is64, bif.out_dst}) | bif.out_imm | bif.out_dval, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 100 && !init_done; n++) @(posedge clk);
    #1;
    issue({32'd64, 16'h0, 4'h0, 4'h1, 8'hDC});
    issue({32'd16, 16'h0, 4'h0, 4'h1, 8'hD4});
    issue({32'd32, 16'h0, 4'h0, 4'h2, 8'hDC});
    issue({32'd16, 16'h0, 4'h0, 4'h2, 8'hDC});
    issue({32'h0, 16'h0, 4'hA, 4'h6, 8'h4F});
    drain();
    rdy_mode = 1;
    issue({32'hFFFF_FFFB, 16'h0, 4'h0, 4'h3, 8'h07});
    fork
      issue({32'h0, 16'h0, 4'h5, 4'h4, 8'h0C});
      begin
        repeat (5) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();
    issue({32'd64, 16'h0, 4'h0, 4'h5, 8'hD4});
    issue({32'd8, 16'h0, 4'h0, 4'h5, 8'hDC});
    issue({32'd1, 16'h0, 4'h0, 4'hA, 8'h07});
    issue({32'd1, 16'h0, 4'hB, 4'h5, 8'h0F});
    issue({32'd7, 16'h0, 4'h0, 4'h5, 8'h87});
    drain();
    wb_keep = 1'b0;
    rdy_mode = 2;
    repeat (300) begin
      if ($urandom_range(3) == 0) idle($urandom_range(3));
      issue(rand_ins());
    end
    rdy_mode = 0;
    drain();
    rdy_mode = 1;
    issue({32'd9, 16'h0, 4'h0, 4'h3, 8'h07});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    wbq.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    foreach (mregs[i]) mregs[i] = '0;
    merr = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bif.out_valid), 64'(0));
    check("midrst_err", 64'(bif.err), 64'(0));
    check("midrst_in_ready", 64'(bif.in_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;
    idle(1);
    issue({32'h0, 16'h0, 4'h3, 4'h3, 8'h0F});
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
